decoder_2x2x4_active_low: RTL and testbench
===========================================

Name: decoder_2x2x4_active_low

Overview:
- Registered 3-to-8 line decoder with active-low outputs.
- Built from two 2-to-4 active-low decoder halves.
- `enable` acts as the most-significant select bit: it chooses the lower half D[0:3] or the upper half D[4:7]. `x`,`y` pick the line within that half.
- Used as a chip-select/one-cold line generator in control paths.

Parameters:
- none (fixed 3-bit select, 8 outputs)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk
- x  input  1  select bit 1 (middle significance)
- y  input  1  select bit 0 (least significant)
- enable  input  1  select bit 2 (most significant); 0 selects half D[0:3], 1 selects half D[4:7]
- D  output  8  one-cold decoded output, declared with ascending index [0:7]; D[0] is the leftmost/most-significant bit position

Behaviour:
- Select index idx = {enable, x, y}, an unsigned value 0..7.
- Combinational decode (next value):
  - D_next[idx] = 0.
  - All other D_next bits = 1.
  - Exactly one bit low for every defined input combination.
- Half structure:
  - enable=0: D[0:3] = 2-to-4 active-low decode of {x,y}; D[4:7] = 1111.
  - enable=1: D[4:7] = 2-to-4 active-low decode of {x,y}; D[0:3] = 1111.
- Output register:
  - D is registered; latency is 1 clock.
  - Inputs sampled at rising edge N appear on D after edge N.
  - D holds between edges; input glitches between edges have no effect.
- Reset:
  - On a rising edge with rst_n=0, D <= 8'b1111_1111 (all lines inactive), regardless of x/y/enable.
  - Reset has priority over decode.
  - Reset is synchronous: asserting rst_n between edges does not change D until the next rising edge.
- Release:
  - First edge with rst_n=1 loads the decode of the inputs sampled at that edge.
- No X propagation requirement beyond simulation semantics. Any X/Z on a select bit may drive D to X; this is not a supported operating point.
- No other outputs, no handshake, no internal state beyond the 8-bit D register.
- Bit-order mapping, written as the 8-bit vector D[0..7] left to right (idx -> D):
  - 0 -> 0111_1111
  - 1 -> 1011_1111
  - 2 -> 1101_1111
  - 3 -> 1110_1111
  - 4 -> 1111_0111
  - 5 -> 1111_1011
  - 6 -> 1111_1101
  - 7 -> 1111_1110

Test Plan:
- Reset: hold rst_n=0 for 2 edges with enable=1,x=1,y=1 -> D=1111_1111 after first edge and stays so while rst_n=0.
- Exhaustive sweep: after reset release, apply {enable,x,y}=0..7, one value per clock.
  - D after each edge must match the mapping table, e.g. idx 0 -> 0111_1111, idx 5 -> 1111_1011, idx 7 -> 1111_1110.
- Latency:
  - Change inputs from idx 2 to idx 6 mid-cycle -> D stays 1101_1111 until the next rising edge, then 1111_1101.
- Half isolation:
  - For all enable=0 cases, D[4:7]=1111.
  - For all enable=1 cases, D[0:3]=1111.
- Reset mid-operation: with D=1111_1110 (idx 7), pull rst_n low between edges.
  - D unchanged until the next edge, then 1111_1111.
  - Release with idx 3 applied -> next edge D=1110_1111.
- Invariant check every cycle after reset release: exactly one bit of D is 0.

Source files
------------

// File: rtl/decoder_2x2x4_active_low.sv
// Registered 3-to-8 one-cold decoder built from two 2-to-4 active-low halves.
// {enable, x, y} forms the line index. enable picks the half: D[0:3] or D[4:7].
// D uses ascending indexing, so D[0] is the leftmost bit and D[idx] is the line that is driven low.
module decoder_2x2x4_active_low (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       x,
    input  logic       y,
    input  logic       enable,
    output logic [0:7] D
);

    // 2-to-4 active-low decode: the selected line is 0 and the other three are 1.
    function automatic logic [0:3] dec_2to4_n(input logic [1:0] sel);
        logic [0:3] lines;
        lines      = 4'b1111;
        lines[sel] = 1'b0;
        return lines;
    endfunction

    logic [0:3] half_lines;
    logic [0:7] d_next;

    // Decode {x,y} once, then steer the result into the half chosen by enable.
    always_comb begin
        // NOTE: give every always_comb output a default first; a path that leaves one unassigned infers a latch.
        d_next     = 8'hFF;
        half_lines = dec_2to4_n({x, y});
        if (enable) begin
            d_next[4:7] = half_lines;
        end else begin
            d_next[0:3] = half_lines;
        end
    end

    // Output register with synchronous reset. Reset takes priority and forces all lines inactive.
    always_ff @(posedge clk) begin
        // NOTE: use non-blocking assignments for registered state so that every flop samples the values from before the edge.
        if (!rst_n) begin
            D <= 8'hFF;
        end else begin
            D <= d_next;
        end
    end

endmodule

// File: tb/tb_decoder_2x2x4_active_low.sv
// Self-checking bench for decoder_2x2x4_active_low. It runs directed steps from the test plan,
// then random traffic checked against an index-shift reference model.
module tb_decoder_2x2x4_active_low;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       x;
    logic       y;
    logic       enable;
    logic [0:7] D;

    int unsigned passed = 0;
    int unsigned total  = 0;

    decoder_2x2x4_active_low dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .x      (x),
        .y      (y),
        .enable (enable),
        .D      (D)
    );

    always #5 clk = ~clk;

    // Reference model: D is read as a plain 8-bit value with D[0] as the MSB.
    // Line idx low therefore means that bit (7-idx) of the value is cleared.
    function automatic logic [7:0] model(input int idx);
        return ~(8'h80 >> idx);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idx(input int idx);
        logic [2:0] s;
        s      = 3'(idx);
        enable = s[2];
        x      = s[1];
        y      = s[0];
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Checks that the unselected half reads 1111 and that exactly one line of D is low.
    task automatic check_shape(input string tag);
        logic [7:0] dv;
        dv = D;
        check({tag, "_iso"}, {4'h0, (enable ? dv[7:4] : dv[3:0])}, 8'h0F);
        check({tag, "_onecold"}, 8'($countones(~dv)), 8'd1);
    endtask

    initial begin
        // Reset is held for two edges with idx 7 applied.
        rst_n = 1'b0;
        set_idx(7);
        tick();
        check("reset_edge1", D, 8'hFF);
        tick();
        check("reset_edge2", D, 8'hFF);

        // Exhaustive sweep: the first edge after release loads idx 0.
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_idx(i);
            tick();
            check($sformatf("sweep_idx%0d", i), D, model(i));
            check_shape($sformatf("sweep_idx%0d", i));
        end
        // Spot checks against table constants.
        set_idx(0); tick(); check("table_idx0", D, 8'b0111_1111);
        set_idx(5); tick(); check("table_idx5", D, 8'b1111_1011);
        set_idx(7); tick(); check("table_idx7", D, 8'b1111_1110);

        // Latency: the input changes mid-cycle and D only follows at the next edge.
        set_idx(2);
        tick();
        check("lat_idx2", D, 8'b1101_1111);
        #3 set_idx(6);
        #1 check("lat_hold", D, 8'b1101_1111);
        tick();
        check("lat_idx6", D, 8'b1111_1101);

        // Reset asserted mid-operation is synchronous.
        set_idx(7);
        tick();
        check("mid_idx7", D, 8'b1111_1110);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_hold", D, 8'b1111_1110);
        tick();
        check("mid_rst_edge", D, 8'hFF);
        rst_n = 1'b1;
        set_idx(3);
        tick();
        check("mid_release_idx3", D, 8'b1110_1111);

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 60; n++) begin
            int  idx;
            logic do_rst;
            idx    = int'($urandom_range(0, 7));
            do_rst = ($urandom_range(0, 7) == 0);
            rst_n  = ~do_rst;
            set_idx(idx);
            tick();
            if (do_rst) begin
                check($sformatf("rand%0d_rst", n), D, 8'hFF);
            end else begin
                check($sformatf("rand%0d_idx%0d", n, idx), D, model(idx));
                check_shape($sformatf("rand%0d", n));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
